// File: rtl/uart_sample_packetizer.sv
// Sample FIFO plus byte framer feeding a one-byte UART transmitter.
// Packet: SYNC_BYTE, sequence byte, then the top bytes of each sample, MSB first.
module uart_sample_packetizer #(
    parameter int          SAMPLE_WIDTH       = 24,
    parameter int          BYTES_PER_SAMPLE   = 2,
    parameter int          FIFO_DEPTH         = 16,
    parameter int          SAMPLES_PER_PACKET = 8,
    parameter logic [7:0]  SYNC_BYTE          = 8'hA5
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic signed [SAMPLE_WIDTH-1:0]    sample_in,
    input  logic                              sample_valid_in,
    input  logic                              enable_in,
    input  logic                              tx_busy_in,
    output logic [7:0]                        byte_out,
    output logic                              byte_valid_out,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count_out,
    output logic                              overflow_out,
    output logic                              packet_done_out
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int SW    = 8 * BYTES_PER_SAMPLE;
    localparam int TOTAL = SAMPLES_PER_PACKET * BYTES_PER_SAMPLE;
    localparam int DLW   = $clog2(TOTAL + 1);
    localparam int BIW   = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;

    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  SPP_C   = CW'(SAMPLES_PER_PACKET);
    localparam logic [DLW-1:0] TOTAL_C = DLW'(TOTAL);
    localparam logic [BIW-1:0] LAST_BI = BIW'(BYTES_PER_SAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SEQ,
        DATA,
        GUARD,
        WAIT
    } state_t;

    state_t state_q, state_d, last_q;

    logic [SW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           ovf_q;
    logic [7:0]     seq_q;
    logic [7:0]     byte_q;
    logic [SW-1:0]  shreg_q;
    logic [DLW-1:0] data_left_q;
    logic [BIW-1:0] byte_idx_q;

    logic          push_ok;
    logic          pop;
    logic          start;
    logic          done;
    logic [SW-1:0] head;

    // Only the transmitted top bytes of each sample are stored.
    if (SAMPLE_WIDTH > SW) begin : g_lsb
        logic unused_lsbs;
        assign unused_lsbs = ^sample_in[SAMPLE_WIDTH-SW-1:0];
    end

    assign head    = mem[rd_ptr_q];
    assign push_ok = sample_valid_in && (count_q < DEPTH_C);
    assign pop     = (state_q == DATA) && (byte_idx_q == '0);
    assign start   = enable_in && (count_q >= SPP_C) && !tx_busy_in;

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE:  if (start) state_d = SYNC;
            SYNC:  state_d = GUARD;
            SEQ:   state_d = GUARD;
            DATA:  state_d = GUARD;
            GUARD: state_d = WAIT;
            WAIT: begin
                if (!tx_busy_in) begin
                    unique case (last_q)
                        SYNC:    state_d = SEQ;
                        SEQ:     state_d = DATA;
                        default: begin
                            if (data_left_q == '0) begin
                                state_d = IDLE;
                                done    = 1'b1;
                            end else begin
                                state_d = DATA;
                            end
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) mem[wr_ptr_q] <= sample_in[SAMPLE_WIDTH-1 -: SW];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_ok) - CW'(pop);
            if (sample_valid_in && !push_ok) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            last_q      <= IDLE;
            seq_q       <= '0;
            byte_q      <= '0;
            shreg_q     <= '0;
            data_left_q <= '0;
            byte_idx_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == SYNC || state_q == SEQ || state_q == DATA)
                last_q <= state_q;
            if (done) seq_q <= seq_q + 8'd1;
            if (state_q == DATA) begin
                data_left_q <= data_left_q - 1'b1;
                byte_idx_q  <= (byte_idx_q == LAST_BI) ? '0 : byte_idx_q + 1'b1;
            end
            // Issue bytes are loaded on entry so byte_out holds until the next issue.
            if (state_d != state_q) begin
                unique case (state_d)
                    SYNC: begin
                        byte_q      <= SYNC_BYTE;
                        data_left_q <= TOTAL_C;
                        byte_idx_q  <= '0;
                    end
                    SEQ: byte_q <= seq_q;
                    DATA: begin
                        if (byte_idx_q == '0) begin
                            byte_q  <= head[SW-1 -: 8];
                            shreg_q <= head << 8;
                        end else begin
                            byte_q  <= shreg_q[SW-1 -: 8];
                            shreg_q <= shreg_q << 8;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign byte_out        = byte_q;
    assign byte_valid_out  = (state_q == SYNC) || (state_q == SEQ) || (state_q == DATA);
    assign fifo_count_out  = count_q;
    assign overflow_out    = ovf_q;
    assign packet_done_out = done;

endmodule

// File: tb/tb_uart_sample_packetizer.sv
// Scoreboard bench for uart_sample_packetizer: expected bytes queued at
// stimulus time, popped by a monitor on every byte_valid_out pulse.
module tb_uart_sample_packetizer;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b0;
    logic signed [23:0] sample_in = '0;
    logic               sample_valid_in = 1'b0;
    logic               enable_in = 1'b0;
    logic               tx_busy_in = 1'b0;
    logic [7:0]         byte_out;
    logic               byte_valid_out;
    logic [4:0]         fifo_count_out;
    logic               overflow_out;
    logic               packet_done_out;

    uart_sample_packetizer dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .enable_in       (enable_in),
        .tx_busy_in      (tx_busy_in),
        .byte_out        (byte_out),
        .byte_valid_out  (byte_valid_out),
        .fifo_count_out  (fifo_count_out),
        .overflow_out    (overflow_out),
        .packet_done_out (packet_done_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;
    int n_bytes = 0;
    int n_done = 0;
    logic [7:0]  exp_q [$];
    logic [23:0] vec [0:31];

    // UART model: busy rises the cycle after a trigger, held busy_len cycles.
    int busy_len = 10;
    int busy_cnt = 0;
    bit pend = 0;
    always @(posedge clk_in) begin
        #1;
        if (!rst_in) begin
            busy_cnt = 0;
            pend = 0;
            tx_busy_in = 1'b0;
        end else begin
            if (busy_cnt > 0) busy_cnt--;
            if (pend) begin
                busy_cnt = busy_len;
                pend = 0;
            end
            if (byte_valid_out) pend = 1;
            tx_busy_in = (busy_cnt > 0);
        end
    end

    always @(negedge clk_in) begin
        if (rst_in) begin
            if (byte_valid_out) begin
                logic [7:0] e;
                n_bytes++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte got=%02h want=none", byte_out);
                end else begin
                    e = exp_q.pop_front();
                    if (byte_out !== e) begin
                        failures++;
                        $display("FAIL byte_stream got=%02h want=%02h", byte_out, e);
                    end
                end
            end
            if (packet_done_out) n_done++;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic exp_packet(input logic [7:0] seq, input int base);
        exp_q.push_back(8'hA5);
        exp_q.push_back(seq);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(vec[base+k][23:16]);
            exp_q.push_back(vec[base+k][15:8]);
        end
    endtask

    task automatic push_sample(input logic [23:0] s);
        sample_in = s;
        sample_valid_in = 1'b1;
        @(negedge clk_in);
        sample_valid_in = 1'b0;
    endtask

    task automatic push_range(input int base, input int n);
        for (int k = 0; k < n; k++) push_sample(vec[base+k]);
    endtask

    task automatic wait_done(input int n, input int budget);
        int c = 0;
        while (n_done < n && c < budget) begin
            @(negedge clk_in);
            c++;
        end
        if (n_done < n) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got=%0d want=%0d", n_done, n);
        end
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int seen = 0;
        int c = 0;
        while (seen < n && c < budget) begin
            @(negedge clk_in);
            if (byte_valid_out) seen++;
            c++;
        end
        if (seen < n) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout got=%0d want=%0d", seen, n);
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        sample_valid_in = 1'b0;
        enable_in = 1'b0;
        repeat (3) @(negedge clk_in);
        exp_q.delete();
        rst_in = 1'b1;
        @(negedge clk_in);
        n_bytes = 0;
        n_done = 0;
    endtask

    initial begin
        vec[0] = 24'h123456; vec[1] = 24'h234567;
        vec[2] = 24'h345678; vec[3] = 24'h456789;
        vec[4] = 24'h56789A; vec[5] = 24'h6789AB;
        vec[6] = 24'h789ABC; vec[7] = 24'h89ABCD;
        for (int i = 8; i < 32; i++)
            vec[i] = {8'(8'hC0 + i), 8'(8'h30 ^ (i * 7)), 8'h5A};

        // reset values
        repeat (2) @(negedge clk_in);
        check("rst_valid", 32'(byte_valid_out), 0);
        check("rst_byte", 32'(byte_out), 0);
        check("rst_count", 32'(fifo_count_out), 0);
        check("rst_ovf", 32'(overflow_out), 0);
        check("rst_done", 32'(packet_done_out), 0);
        do_reset();

        // basic packet
        busy_len = 10;
        enable_in = 1'b1;
        exp_packet(8'h00, 0);
        push_range(0, 8);
        wait_done(1, 1000);
        repeat (5) @(negedge clk_in);
        check("basic_bytes", 32'(n_bytes), 18);
        check("basic_done", 32'(n_done), 1);
        check("basic_count", 32'(fifo_count_out), 0);
        check("basic_queue", 32'(exp_q.size()), 0);

        // sequence wrap over 257 packets
        do_reset();
        busy_len = 1;
        enable_in = 1'b1;
        for (int p = 0; p < 257; p++) begin
            exp_packet(8'(p), 0);
            push_range(0, 8);
            wait_done(p + 1, 400);
        end
        repeat (5) @(negedge clk_in);
        check("wrap_done", 32'(n_done), 257);
        check("wrap_queue", 32'(exp_q.size()), 0);

        // overflow: 17 pushes with enable low
        do_reset();
        busy_len = 10;
        push_range(0, 17);
        check("ovf_count", 32'(fifo_count_out), 16);
        check("ovf_flag", 32'(overflow_out), 1);
        exp_packet(8'h00, 0);
        exp_packet(8'h01, 8);
        enable_in = 1'b1;
        wait_done(2, 2000);
        repeat (40) @(negedge clk_in);
        check("ovf_pkts", 32'(n_done), 2);
        check("ovf_count_end", 32'(fifo_count_out), 0);
        check("ovf_queue", 32'(exp_q.size()), 0);
        check("ovf_sticky", 32'(overflow_out), 1);

        // push in the pop cycle while full
        do_reset();
        push_range(0, 16);
        check("full_ovf_pre", 32'(overflow_out), 0);
        exp_packet(8'h00, 0);
        exp_packet(8'h01, 8);
        enable_in = 1'b1;
        wait_bytes(3, 200);
        sample_in = vec[16];
        sample_valid_in = 1'b1;
        @(negedge clk_in);
        sample_valid_in = 1'b0;
        check("full_count", 32'(fifo_count_out), 15);
        check("full_ovf", 32'(overflow_out), 1);
        wait_done(2, 2000);
        repeat (40) @(negedge clk_in);
        check("full_count_end", 32'(fifo_count_out), 0);
        check("full_queue", 32'(exp_q.size()), 0);

        // enable dropped mid-packet
        do_reset();
        push_range(0, 16);
        exp_packet(8'h00, 0);
        enable_in = 1'b1;
        wait_bytes(3, 200);
        enable_in = 1'b0;
        wait_done(1, 1000);
        repeat (60) @(negedge clk_in);
        check("en_bytes", 32'(n_bytes), 18);
        check("en_done", 32'(n_done), 1);
        check("en_count", 32'(fifo_count_out), 8);

        // async reset while waiting on the transmitter
        exp_packet(8'h01, 8);
        enable_in = 1'b1;
        wait_bytes(1, 100);
        repeat (4) @(negedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        check("arst_valid", 32'(byte_valid_out), 0);
        check("arst_byte", 32'(byte_out), 0);
        check("arst_count", 32'(fifo_count_out), 0);
        check("arst_ovf", 32'(overflow_out), 0);
        check("arst_done", 32'(packet_done_out), 0);
        exp_q.delete();
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        n_bytes = 0;
        n_done = 0;
        repeat (30) @(negedge clk_in);
        check("arst_idle_bytes", 32'(n_bytes), 0);
        exp_packet(8'h00, 16);
        push_range(16, 8);
        wait_done(1, 1000);
        repeat (5) @(negedge clk_in);
        check("arst_pkt_bytes", 32'(n_bytes), 18);
        check("arst_queue", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
